// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// alu_muldiv: EX-stage ALU with an iterative multiply/divide unit and HI/LO.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply.
// Revision: 1.0
// ============================================================================
module alu_muldiv #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ctrl,
  input  logic [2:0]       md_op,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_XOR  = 4'd10;
  localparam logic [3:0] ALU_NOR  = 4'd11;
  localparam logic [3:0] ALU_MFHI = 4'd12;
  localparam logic [3:0] ALU_MFLO = 4'd13;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;
  localparam logic [2:0] MD_RSVD  = 3'd7;

  localparam logic [SHAMT_W-1:0] DIV_CNT = SHAMT_W'(WIDTH - 1);
`ifdef MULDIV_FAST_MUL_EN
  localparam logic [SHAMT_W-1:0] MUL_CNT = '0;
`else
  localparam logic [SHAMT_W-1:0] MUL_CNT = SHAMT_W'(WIDTH - 1);
`endif

  logic               busy_q, done_q, is_div_q, neg_q, rneg_q, dz_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [WIDTH-1:0]   acc_q, shq_q, m_q, a_q, hi_q, lo_q;

  logic [SHAMT_W-1:0] shamt;
  assign shamt = B[SHAMT_W-1:0];

  always_comb begin
    out = '0;
    case (ctrl)
      ALU_ADD:  out = A + B;
      ALU_SUB:  out = A - B;
      ALU_OR:   out = A | B;
      ALU_AND:  out = A & B;
      ALU_SLL:  out = A << shamt;
      ALU_SRL:  out = A >> shamt;
      ALU_SRA:  out = $signed(A) >>> shamt;
      ALU_SLT:  out = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU: out = {{(WIDTH-1){1'b0}}, (A < B)};
      ALU_XOR:  out = A ^ B;
      ALU_NOR:  out = ~(A | B);
      ALU_MFHI: out = hi_q;
      ALU_MFLO: out = lo_q;
      default:  out = '0;
    endcase
  end

  logic             signed_op, accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign signed_op = (md_op == MD_MULT) || (md_op == MD_DIV);
  assign a_mag     = (signed_op && A[WIDTH-1]) ? -A : A;
  assign b_mag     = (signed_op && B[WIDTH-1]) ? -B : B;
  assign accept    = start && !busy_q && (md_op != MD_NONE) && (md_op != MD_RSVD);

  // Multiply: {acc, shq} is the shifting product, multiplier consumed from shq LSB.
  logic [WIDTH:0]   mul_sum_d;
  logic [WIDTH-1:0] mul_hi_d, mul_lo_d;
  assign mul_sum_d = {1'b0, acc_q} + (shq_q[0] ? {1'b0, m_q} : '0);
  assign mul_hi_d  = mul_sum_d[WIDTH:1];
  assign mul_lo_d  = {mul_sum_d[0], shq_q[WIDTH-1:1]};

  // Divide: acc is the partial remainder, shq shifts dividend out and quotient in.
  logic [WIDTH:0]   div_sh_d, div_diff_d;
  logic             div_ge;
  logic [WIDTH-1:0] rem_d, quo_d;
  assign div_sh_d   = {acc_q, shq_q[WIDTH-1]};
  assign div_diff_d = div_sh_d - {1'b0, m_q};
  assign div_ge     = ~div_diff_d[WIDTH];
  assign rem_d      = div_ge ? div_diff_d[WIDTH-1:0] : div_sh_d[WIDTH-1:0];
  assign quo_d      = {shq_q[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] prod_d, prod_res_d;
`ifdef MULDIV_FAST_MUL_EN
  assign prod_d = {{WIDTH{1'b0}}, m_q} * {{WIDTH{1'b0}}, shq_q};
`else
  assign prod_d = {mul_hi_d, mul_lo_d};
`endif
  assign prod_res_d = neg_q ? -prod_d : prod_d;

  logic [WIDTH-1:0] res_hi_d, res_lo_d;
  always_comb begin
    res_hi_d = prod_res_d[2*WIDTH-1:WIDTH];
    res_lo_d = prod_res_d[WIDTH-1:0];
    if (is_div_q) begin
      if (dz_q) begin
        res_hi_d = a_q;
        res_lo_d = '1;
      end else begin
        res_hi_d = rneg_q ? -rem_d : rem_d;
        res_lo_d = neg_q  ? -quo_d : quo_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      shq_q    <= '0;
      m_q      <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        if (is_div_q) begin
          acc_q <= rem_d;
          shq_q <= quo_d;
        end else begin
          acc_q <= mul_hi_d;
          shq_q <= mul_lo_d;
        end
        if (cnt_q == '0) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          hi_q   <= res_hi_d;
          lo_q   <= res_lo_d;
        end else begin
          cnt_q <= cnt_q - SHAMT_W'(1);
        end
      end else if (accept) begin
        case (md_op)
          MD_MTHI: hi_q <= A;
          MD_MTLO: lo_q <= A;
          default: begin
            busy_q   <= 1'b1;
            is_div_q <= (md_op == MD_DIV) || (md_op == MD_DIVU);
            cnt_q    <= ((md_op == MD_DIV) || (md_op == MD_DIVU)) ? DIV_CNT : MUL_CNT;
            neg_q    <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
            rneg_q   <= signed_op && A[WIDTH-1];
            dz_q     <= (B == '0);
            acc_q    <= '0;
            shq_q    <= a_mag;
            m_q      <= b_mag;
            a_q      <= A;
          end
        endcase
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
// tb_alu_muldiv: randomized + directed self-checking bench for alu_muldiv.
// Revision: 1.0
// ============================================================================
module tb_alu_muldiv;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 32;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] A, B;
  logic [3:0]   ctrl;
  logic [2:0]   md_op;
  logic         start;
  logic [W-1:0] out, hi, lo;
  logic         busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .ctrl(ctrl), .md_op(md_op),
    .start(start), .out(out), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  function automatic logic [W-1:0] ref_alu(input logic [3:0] c, input logic [W-1:0] a, b, h, l);
    int sh;
    logic signed [W-1:0] sa;
    sh = int'(b[4:0]);
    sa = a;
    case (c)
      4'd1:  return a + b;
      4'd2:  return a - b;
      4'd3:  return a | b;
      4'd4:  return a & b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return sa >>> sh;
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return a ^ b;
      4'd11: return ~(a | b);
      4'd12: return h;
      4'd13: return l;
      default: return 32'd0;
    endcase
  endfunction

  // Returns {hi, lo} computed with plain 64-bit / C-style arithmetic.
  function automatic logic [2*W-1:0] ref_md(input logic [2:0] op, input logic [W-1:0] a, b);
    longint sp;
    logic [2*W-1:0] up;
    logic signed [W-1:0] sa, sb, q, r;
    sa = a;
    sb = b;
    case (op)
      3'd1: begin sp = longint'(sa) * longint'(sb); return sp; end
      3'd2: begin up = {32'd0, a} * {32'd0, b}; return up; end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      3'd4: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return '0;
    endcase
  endfunction

  int           m_busy;
  logic         m_done;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic [2*W-1:0] w_ref;
  always_comb w_ref = ref_md(md_op, A, B);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
    end else if (m_busy != 0) begin
      m_busy <= m_busy - 1;
      m_done <= (m_busy == 1);
      if (m_busy == 1) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        case (md_op)
          3'd1, 3'd2: begin p_hi <= w_ref[63:32]; p_lo <= w_ref[31:0]; m_busy <= MUL_LAT; end
          3'd3, 3'd4: begin p_hi <= w_ref[63:32]; p_lo <= w_ref[31:0]; m_busy <= 32; end
          3'd5: m_hi <= A;
          3'd6: m_lo <= A;
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always begin
    @(negedge clk);
    #1;
    chk("out",  out, ref_alu(ctrl, A, B, m_hi, m_lo));
    chk("busy", {31'd0, busy}, {31'd0, (m_busy != 0)});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("hi",   hi, m_hi);
    chk("lo",   lo, m_lo);
  end

  task automatic step(input logic [3:0] c, input logic [2:0] op, input logic s,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    ctrl  = c;
    md_op = op;
    start = s;
    A     = a;
    B     = b;
    #2;
  endtask

  task automatic run_to_done(output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      step(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 1'b0, $urandom, $urandom);
      if (done) return;
      if (busy) nbusy++;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL done_timeout: got no done within 40 cycles, required done at %0t", $time);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  int nb;

  initial begin
    reset = 1'b1;
    ctrl = 4'd0; md_op = 3'd0; start = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #2;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    step(4'd7, 3'd0, 1'b0, 32'h8000_0000, 32'd4);
    chk("sra_lit", out, 32'hF800_0000);
    step(4'd8, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    chk("slt_lit", out, 32'd1);
    step(4'd9, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    chk("sltu_lit", out, 32'd0);

    step(4'd0, 3'd1, 1'b1, 32'hFFFF_FFFE, 32'd3);
    run_to_done(nb);
    chk("mul_lat", 32'(nb), 32'(MUL_LAT));
    chk("mul_hi", hi, 32'hFFFF_FFFF);
    chk("mul_lo", lo, 32'hFFFF_FFFA);
    step(4'd0, 3'd0, 1'b0, 32'd0, 32'd0);
    chk("done_pulse", {31'd0, done}, 32'd0);

    step(4'd0, 3'd3, 1'b1, 32'hFFFF_FFF9, 32'd2);
    step(4'd0, 3'd5, 1'b1, 32'h1234, $urandom);
    run_to_done(nb);
    chk("div_lat", 32'(nb), 32'd31);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    // accepted in the done cycle
    ctrl = 4'd0; md_op = 3'd6; start = 1'b1; A = 32'h55;
    step(4'd13, 3'd0, 1'b0, 32'd0, 32'd0);
    chk("mtlo_out", out, 32'h55);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    chk("mtlo_hi", hi, 32'hFFFF_FFFF);

    step(4'd0, 3'd4, 1'b1, 32'd7, 32'd0);
    run_to_done(nb);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_hi", hi, 32'd7);

    step(4'd0, 3'd3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_to_done(nb);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);

    step(4'd0, 3'd5, 1'b1, 32'hAAAA, 32'd0);
    step(4'd0, 3'd3, 1'b1, 32'd100, 32'd7);
    repeat (9) step(4'd0, 3'd0, 1'b0, $urandom, $urandom);
    @(negedge clk);
    start = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    #2 reset = 1'b0;
    step(4'd0, 3'd4, 1'b1, 32'd100, 32'd7);
    run_to_done(nb);
    chk("post_rst_lo", lo, 32'd14);
    chk("post_rst_hi", hi, 32'd2);

    for (int i = 0; i < 4000; i++)
      step(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
           pick(), pick());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised successor to the single-cycle ALU.
- Keeps a combinational datapath for simple ops and extends the op set.
- Adds an iterative multiply/divide unit with HI/LO registers and a start/busy handshake.
- Sits in EX stage; hazard unit stalls on busy.

Parameters:
- WIDTH, 32, operand/result width; must be a power of two, >= 8.
- SHAMT_W, 5, shift-amount bits taken from B[SHAMT_W-1:0]; must equal log2(WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- A  in  WIDTH  operand A (rs).
- B  in  WIDTH  operand B (rt/imm).
- ctrl  in  4  ALU op: 0 disabled, 1 add, 2 sub, 3 or, 4 and, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu, 10 xor, 11 nor, 12 mfhi, 13 mflo; 14-15 reserved.
- md_op  in  3  muldiv op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 reserved.
- start  in  1  qualifies md_op for one cycle.
- out  out  WIDTH  combinational result.
- busy  out  1  muldiv operation in progress.
- done  out  1  one-cycle pulse when HI/LO hold a new mult/div result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async): hi=0, lo=0, busy=0, done=0, iteration counter=0. Reset mid-operation aborts the op; no partial HI/LO write.
- out (combinational, no latency):
  - add/sub wrap modulo 2^WIDTH.
  - Shifts shift A by B[SHAMT_W-1:0]; sra sign-fills.
  - slt/sltu give zero-extended 1/0.
  - mfhi/mflo output current hi/lo.
  - ctrl 0 and reserved codes give 0.
- Start acceptance: start accepted at a rising edge when start=1, busy=0, md_op in 1..6.
  - start while busy=1 is ignored; operation and HI/LO unchanged.
  - md_op 0 or 7 with start: ignored.
- mthi/mtlo: hi (or lo) <= A at the accepting edge; busy stays 0; done stays 0.
- mult/multu/div/divu:
  - Operands latched at the accepting edge; busy=1 from the following cycle for exactly WIDTH cycles.
  - At the edge ending the last busy cycle: hi/lo written, busy falls to 0, done=1 for one cycle.
  - New start is accepted in the done cycle.
- Multiply: shift-add on magnitudes, 2*WIDTH product.
  - hi = upper half, lo = lower half.
  - Signed result negated when sign(A) xor sign(B).
- Divide: restoring on magnitudes. lo = quotient, hi = remainder.
  - Quotient sign = sign(A) xor sign(B); remainder sign = sign(A) (truncating, C semantics).
- Divide by zero: lo = all ones, hi = A. Same WIDTH-cycle latency.
- Signed overflow (div, A = most negative, B = -1): lo = A, hi = 0.
- Inputs A/B may change while busy without affecting the result.
- hi/lo change only at reset, mthi/mtlo, or mult/div completion.

Optional Feature:
- MULDIV_FAST_MUL_EN defined: mult/multu use a combinational product.
  - busy=1 for exactly 1 cycle.
  - HI/LO written at the edge ending that cycle; done pulses next cycle.
  - div/divu unchanged.
- Undefined: multiply is iterative, WIDTH-cycle latency as above.

Test Plan:
- Reset asserted mid-divide (cycle 10 of 32) -> busy, done, hi, lo = 0 immediately (asynchronously); next start is accepted normally.
- ctrl=7 A=0x80000000 B=4 -> out=0xF8000000; ctrl=8 A=0xFFFFFFFF B=1 -> out=1; ctrl=9 same operands -> out=0.
- start md_op=1 A=0xFFFFFFFE(-2) B=3 -> busy 32 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done one cycle; with MULDIV_FAST_MUL_EN busy 1 cycle, same result.
- start md_op=3 A=-7 B=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1); md_op=4 A=7 B=0 -> lo=0xFFFFFFFF, hi=7.
- start md_op=3 A=0x80000000 B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- During busy: start md_op=5 A=0x1234 and change A/B -> ignored, final HI/LO match the original operands; after done, md_op=6 A=0x55 -> lo=0x55 next cycle, busy never rises; ctrl=13 -> out=0x55.
